// File: rtl/fetch_entry_queue_pkg.sv
// Shared types and sizing for the fetch-entry queue between frontend and decode.
package fetch_entry_queue_pkg;

  localparam int unsigned INSTR_PER_FETCH = 2;
  localparam int unsigned FEQ_DEPTH       = 4;
  localparam int unsigned VLEN            = 32;
  localparam int unsigned ILEN            = 32;
  localparam int unsigned CAUSE_W         = 4;

  typedef struct packed {
    logic               valid;
    logic [CAUSE_W-1:0] cause;
  } exception_t;

  typedef struct packed {
    logic [VLEN-1:0] address;
    logic [ILEN-1:0] instruction;
    exception_t      ex;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_entry_queue.sv
// Buffers realigned fetch groups from the frontend and hands them to decode
// one entry per cycle, in program order, over a valid/ready handshake.
module fetch_entry_queue
  import fetch_entry_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FEQ_DEPTH,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  input  logic                       flush_i,
  input  fetch_entry_t               instr_i [INSTR_PER_FETCH],
  input  logic [INSTR_PER_FETCH-1:0] instr_valid_i,
  output logic                       instr_ready_o,
  output fetch_entry_t               fetch_entry_o,
  output logic                       fetch_entry_valid_o,
  input  logic                       fetch_entry_ready_i,
  output logic [CntW-1:0]            occupancy_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t    r_mem [DEPTH];
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW-1:0] r_wr_ptr;
  logic [CntW-1:0] r_count;

  logic [PtrW-1:0] w_offset [INSTR_PER_FETCH];
  logic [CntW-1:0] w_push_cnt;
  logic            w_clear;
  logic            w_enq;
  logic            w_deq;

  // Prefix-sum over the valid mask: each valid slot lands at wr_ptr + (valid slots below it).
  always_comb begin
    w_push_cnt = '0;
    for (int unsigned i = 0; i < INSTR_PER_FETCH; i++) begin
      w_offset[i] = PtrW'(w_push_cnt);
      w_push_cnt  = w_push_cnt + CntW'(instr_valid_i[i]);
    end
  end

  // Ready looks only at the registered count so decode's ready never reaches the frontend.
  assign instr_ready_o       = (CntW'(DEPTH) - r_count) >= CntW'(INSTR_PER_FETCH);
  assign fetch_entry_valid_o = (r_count != '0);
  assign fetch_entry_o       = r_mem[r_rd_ptr];
  assign occupancy_o         = r_count;

  assign w_clear = flush_i | clr_i;
  assign w_enq   = instr_ready_o & (|instr_valid_i) & ~w_clear;
  assign w_deq   = fetch_entry_valid_o & fetch_entry_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(w_push_cnt);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      r_count <= r_count + (w_enq ? w_push_cnt : CntW'(0)) - CntW'(w_deq);
    end
  end

  // Storage is zeroed on reset only so fetch_entry_o reads '0 out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_enq) begin
      for (int unsigned i = 0; i < INSTR_PER_FETCH; i++) begin
        if (instr_valid_i[i]) begin
          r_mem[r_wr_ptr + w_offset[i]] <= instr_i[i];
        end
      end
    end
  end

  a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_count <= CntW'(DEPTH));
  a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_deq && (r_count == '0)));
  a_enq_needs_ready : assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_enq |-> instr_ready_o);

endmodule

// File: tb/tb_fetch_entry_queue.sv
// Randomized and directed bench for fetch_entry_queue with a queue-based reference model.
module tb_fetch_entry_queue;
  import fetch_entry_queue_pkg::*;

  localparam int unsigned IPF   = INSTR_PER_FETCH;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               clr_i;
  logic               flush_i;
  fetch_entry_t       instr [IPF];
  logic [IPF-1:0]     mask;
  logic               instr_ready_o;
  fetch_entry_t       fetch_entry_o;
  logic               fetch_entry_valid_o;
  logic               rdy;
  logic [CntW-1:0]    occupancy_o;

  always #5 clk_i = ~clk_i;

  fetch_entry_queue #(.DEPTH(DEPTH)) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .clr_i               (clr_i),
    .flush_i             (flush_i),
    .instr_i             (instr),
    .instr_valid_i       (mask),
    .instr_ready_o       (instr_ready_o),
    .fetch_entry_o       (fetch_entry_o),
    .fetch_entry_valid_o (fetch_entry_valid_o),
    .fetch_entry_ready_i (rdy),
    .occupancy_o         (occupancy_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the queue contents are the scoreboard, m_cnt the architectural count.
  fetch_entry_t sb[$];
  int           m_cnt = 0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic fetch_entry_t mk(int n);
    fetch_entry_t e;
    e.address     = 32'h1000 + 32'(n) * 32'd4;
    e.instruction = 32'(n);
    e.ex          = '0;
    return e;
  endfunction

  function automatic fetch_entry_t rand_entry();
    fetch_entry_t e;
    e.address     = $urandom;
    e.instruction = $urandom;
    e.ex.valid    = 1'($urandom_range(0, 1));
    e.ex.cause    = 4'($urandom_range(0, 15));
    return e;
  endfunction

  function automatic bit model_ready();
    return (int'(DEPTH) - m_cnt) >= int'(IPF);
  endfunction

  // Model advances on the same edge as the DUT, from the bench's own inputs only.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_cnt = 0;
      sb.delete();
    end else begin
      bit deq;
      bit acc;
      deq = (m_cnt != 0) && rdy;
      acc = model_ready() && (mask != '0);
      if (flush_i || clr_i) begin
        m_cnt = 0;
        sb.delete();
      end else begin
        if (deq) m_cnt--;
        if (acc) begin
          for (int i = 0; i < int'(IPF); i++) begin
            if (mask[i]) begin
              sb.push_back(instr[i]);
              m_cnt++;
            end
          end
        end
      end
    end
  end

  // Monitor: compares handshake outputs mid-cycle and pops on every accepted entry.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      chk("valid_o", 128'(fetch_entry_valid_o), 128'(m_cnt != 0));
      chk("occupancy_o", 128'(occupancy_o), 128'(m_cnt));
      chk("instr_ready_o", 128'(instr_ready_o), 128'(model_ready()));
      if (fetch_entry_valid_o) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL entry_order: DUT valid with entry %h but reference queue empty", fetch_entry_o);
        end else if (rdy) begin
          fetch_entry_t e;
          e = sb.pop_front();
          chk("entry_pop", 128'(fetch_entry_o), 128'(e));
        end else begin
          chk("entry_head", 128'(fetch_entry_o), 128'(sb[0]));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Offers a group until the model accepts it, as a frontend holding its data would.
  task automatic offer(input fetch_entry_t e0, input fetch_entry_t e1, input logic [IPF-1:0] m);
    bit done = 0;
    instr[0] = e0;
    instr[1] = e1;
    mask     = m;
    for (int t = 0; t < 20 && !done; t++) begin
      done = model_ready();
      step();
    end
    if (!done) chk("offer_timeout", 128'(0), 128'(1));
    mask = '0;
  endtask

  initial begin
    rst_ni  = 1'b0;
    clr_i   = 1'b0;
    flush_i = 1'b0;
    mask    = '0;
    rdy     = 1'b0;
    instr[0] = '0;
    instr[1] = '0;
    repeat (3) step();
    rst_ni = 1'b1;
    chk("reset_entry", 128'(fetch_entry_o), 128'(0));
    repeat (10) step();

    // {A,B} in one cycle, then drain
    instr[0] = mk(1); instr[1] = mk(2); mask = 2'b11;
    step();
    mask = '0; rdy = 1'b1;
    repeat (3) step();
    rdy = 1'b0;

    // non-contiguous masks
    instr[0] = mk(3); instr[1] = mk(4); mask = 2'b10;
    step();
    instr[0] = mk(5); instr[1] = mk(6); mask = 2'b01;
    step();
    mask = '0;
    step();
    rdy = 1'b1;
    repeat (3) step();
    rdy = 1'b0;

    // fill one at a time; fourth offer lands while ready is low
    for (int k = 0; k < 4; k++) begin
      instr[0] = mk(20 + k); mask = 2'b01;
      step();
    end
    mask = '0;
    chk("full_ready_low", 128'(instr_ready_o), 128'(0));
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    chk("ready_reopen", 128'(instr_ready_o), 128'(1));
    step();
    rdy = 1'b1;
    repeat (4) step();
    chk("drain_empty", 128'(sb.size()), 128'(0));

    // wrap: 6 groups of 2 with continuous dequeue
    for (int g = 0; g < 6; g++) offer(mk(40 + 2 * g), mk(41 + 2 * g), 2'b11);
    repeat (6) step();
    chk("wrap_empty", 128'(occupancy_o), 128'(0));
    rdy = 1'b0;

    // flush at count 3 with a concurrent offer, then new entries come out first
    offer(mk(60), mk(61), 2'b11);
    offer(mk(62), mk(0), 2'b01);
    instr[0] = mk(63); instr[1] = mk(64); mask = 2'b11; flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("flush_occ", 128'(occupancy_o), 128'(0));
    instr[0] = mk(65); instr[1] = mk(66); mask = 2'b11;
    step();
    mask = '0; rdy = 1'b1;
    repeat (4) step();

    // random traffic with occasional flush, clear and an async reset
    for (int i = 0; i < 1500; i++) begin
      instr[0] = rand_entry();
      instr[1] = rand_entry();
      mask     = 2'($urandom_range(0, 3));
      rdy      = ($urandom_range(0, 3) != 0);
      flush_i  = ($urandom_range(0, 39) == 0);
      clr_i    = ($urandom_range(0, 59) == 0);
      if (i == 700) begin
        #2 rst_ni = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
        chk("midrun_reset_occ", 128'(occupancy_o), 128'(0));
        chk("midrun_reset_entry", 128'(fetch_entry_o), 128'(0));
      end
      step();
    end
    mask = '0; flush_i = 1'b0; clr_i = 1'b0; rdy = 1'b1;
    repeat (6) step();
    chk("final_empty", 128'(sb.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
